// File: rtl/alu_decode_stage.sv
// ============================================================================
// Module      : alu_decode_stage
// Description : Decodes RV32I instructions into ALU controls and operands.
//               The decoded results are held in an output-registered
//               valid/ready stage.
//               All outputs are driven from registers.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Configuration macro : DECODE_SKID_EN
//   defined   - two-entry skid buffer, inReady registered
//   undefined - single entry, inReady = !outValid || outReady
// ----------------------------------------------------------------------------
// Ports
//   clk, rstN                      clock, async active-low reset
//   inValid/inReady                upstream handshake
//   instr, pc, rs1Data, rs2Data    instruction, its PC, register operands
//   flush                          drops every held entry
//   outValid/outReady              downstream (ALU) handshake
//   aluCntrl, useF7, inv           ALU op, sub/sra select, compare inversion
//   srcA, srcB, outPc              ALU operands, PC passthrough
//   isBranch, isJump, illegal      mutually exclusive class flags
// ============================================================================
`default_nettype none

module alu_decode_stage (
    input  logic        clk,
    input  logic        rstN,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1Data,
    input  logic [31:0] rs2Data,
    input  logic        flush,
    output logic        outValid,
    input  logic        outReady,
    output logic [2:0]  aluCntrl,
    output logic        useF7,
    output logic        inv,
    output logic [31:0] srcA,
    output logic [31:0] srcB,
    output logic [31:0] outPc,
    output logic        isBranch,
    output logic        isJump,
    output logic        illegal
);

    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [2:0]  alu;
        logic        useF7;
        logic        inv;
        logic [31:0] srcA;
        logic [31:0] srcB;
        logic [31:0] pc;
        logic        isBranch;
        logic        isJump;
        logic        illegal;
    } dec_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Instruction decode (combinational, captured into the entry regs)
    // ------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [31:0] w_immI;
    logic [31:0] w_immS;
    logic [31:0] w_immU;
    dec_t        w_dec;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_immI   = {{20{instr[31]}}, instr[31:20]};
    assign w_immS   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_immU   = {instr[31:12], 12'd0};

    always_comb begin
        w_dec    = '0;
        w_dec.pc = pc;
        case (w_opcode)
            c_OP_OP: begin
                w_dec.alu   = w_funct3;
                w_dec.useF7 = instr[30];
                w_dec.srcA  = rs1Data;
                w_dec.srcB  = rs2Data;
            end
            c_OP_IMM: begin
                w_dec.alu   = w_funct3;
                w_dec.useF7 = (w_funct3 == 3'b101) && instr[30];
                w_dec.srcA  = rs1Data;
                // funct3 001/101 are shifts: shamt only, zero-extended
                w_dec.srcB  = (w_funct3[1:0] == 2'b01) ? {27'd0, instr[24:20]} : w_immI;
            end
            c_OP_BRANCH: begin
                if (w_funct3[2:1] == 2'b01) begin
                    w_dec.illegal = 1'b1;
                end else begin
                    w_dec.isBranch = 1'b1;
                    w_dec.inv      = w_funct3[0];
                    w_dec.srcA     = rs1Data;
                    w_dec.srcB     = rs2Data;
                    case (w_funct3[2:1])
                        2'b00: begin
                            w_dec.alu   = 3'b000;
                            w_dec.useF7 = 1'b1;   // subtract for equality test
                        end
                        2'b10:   w_dec.alu = 3'b010;
                        default: w_dec.alu = 3'b011;
                    endcase
                end
            end
            c_OP_LOAD: begin
                w_dec.srcA = rs1Data;
                w_dec.srcB = w_immI;
            end
            c_OP_STORE: begin
                w_dec.srcA = rs1Data;
                w_dec.srcB = w_immS;
            end
            c_OP_LUI: begin
                w_dec.srcB = w_immU;
            end
            c_OP_AUIPC: begin
                w_dec.srcA = pc;
                w_dec.srcB = w_immU;
            end
            c_OP_JAL, c_OP_JALR: begin
                w_dec.isJump = 1'b1;
                w_dec.srcA   = pc;
                w_dec.srcB   = 32'd4;
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Occupancy FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_stateNext;
    logic   w_inFire;
    logic   w_outFire;
    logic   w_loadHead;
    logic   w_headFromTail;
    logic   w_loadTail;
    dec_t   r_head;

    assign outValid  = (r_state != ST_EMPTY);
    assign w_inFire  = inValid && inReady;
    assign w_outFire = outValid && outReady;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_loadHead     = 1'b0;
        w_headFromTail = 1'b0;
        w_loadTail     = 1'b0;
        if (flush) begin
            w_stateNext = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_inFire) begin
                        w_loadHead  = 1'b1;
                        w_stateNext = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_inFire && w_outFire) begin
                        w_loadHead = 1'b1;
                    end else if (w_inFire) begin
`ifdef DECODE_SKID_EN
                        w_loadTail  = 1'b1;
                        w_stateNext = ST_TWO;
`else
                        // unreachable: inReady implies outReady while full
                        w_loadHead  = 1'b1;
`endif
                    end else if (w_outFire) begin
                        w_stateNext = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // inReady is low here, so only a drain can occur
                    if (w_outFire) begin
                        w_loadHead     = 1'b1;
                        w_headFromTail = 1'b1;
                        w_stateNext    = ST_ONE;
                    end
                end
                default: begin
                    w_stateNext = ST_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry storage and ready generation
    // ------------------------------------------------------------------
`ifdef DECODE_SKID_EN
    dec_t r_tail;
    logic r_inReady;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_tail    <= '0;
            r_inReady <= 1'b1;
        end else begin
            if (w_loadTail) begin
                r_tail <= w_dec;
            end
            r_inReady <= (w_stateNext != ST_TWO);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_head <= '0;
        end else if (w_loadHead) begin
            r_head <= w_headFromTail ? r_tail : w_dec;
        end
    end

    assign inReady = r_inReady;
`else
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_head <= '0;
        end else if (w_loadHead && !w_headFromTail) begin
            r_head <= w_dec;
        end
    end

    assign inReady = !outValid || outReady;
`endif

    assign aluCntrl = r_head.alu;
    assign useF7    = r_head.useF7;
    assign inv      = r_head.inv;
    assign srcA     = r_head.srcA;
    assign srcB     = r_head.srcB;
    assign outPc    = r_head.pc;
    assign isBranch = r_head.isBranch;
    assign isJump   = r_head.isJump;
    assign illegal  = r_head.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_decode_stage.sv
// ============================================================================
// Module      : tb_alu_decode_stage
// Description : Self-checking bench for alu_decode_stage: directed decode
//               table, multi-cycle handshake sequences, and randomized
//               traffic checked against a queue-based reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_decode_stage;

`ifdef DECODE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [2:0]  alu;
        logic        useF7;
        logic        inv;
        logic [31:0] srcA;
        logic [31:0] srcB;
        logic [31:0] pc;
        logic        isBranch;
        logic        isJump;
        logic        illegal;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        exp_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        inValid, inReady;
    logic [31:0] instr, pc, rs1Data, rs2Data;
    logic        flush;
    logic        outValid, outReady;
    logic [2:0]  aluCntrl;
    logic        useF7, inv;
    logic [31:0] srcA, srcB, outPc;
    logic        isBranch, isJump, illegal;

    int vectors = 0;
    int miscompares = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    alu_decode_stage dut (
        .clk      (clk),
        .rstN     (rstN),
        .inValid  (inValid),
        .inReady  (inReady),
        .instr    (instr),
        .pc       (pc),
        .rs1Data  (rs1Data),
        .rs2Data  (rs2Data),
        .flush    (flush),
        .outValid (outValid),
        .outReady (outReady),
        .aluCntrl (aluCntrl),
        .useF7    (useF7),
        .inv      (inv),
        .srcA     (srcA),
        .srcB     (srcB),
        .outPc    (outPc),
        .isBranch (isBranch),
        .isJump   (isJump),
        .illegal  (illegal)
    );

    function automatic exp_t got();
        return '{aluCntrl, useF7, inv, srcA, srcB, outPc, isBranch, isJump, illegal};
    endfunction

    // Reference decode, written straight from the RV32I field definitions
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                        input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        int          f3;
        logic [31:0] immI, immS, immU;
        f3   = int'(ins[14:12]);
        immI = 32'($signed(ins) >>> 20);
        immS = (immI & ~32'h1F) | {27'd0, ins[11:7]};
        immU = ins & 32'hFFFF_F000;
        e    = '0;
        e.pc = p;
        case (ins[6:0])
            7'h33: e = '{3'(f3), ins[30], 1'b0, a, b, p, 1'b0, 1'b0, 1'b0};
            7'h13: e = '{3'(f3), (f3 == 5) ? ins[30] : 1'b0, 1'b0, a,
                         (f3 == 1 || f3 == 5) ? (ins >> 20) & 32'h1F : immI,
                         p, 1'b0, 1'b0, 1'b0};
            7'h63: begin
                if (f3 == 2 || f3 == 3) e.illegal = 1'b1;
                else if (f3 < 2)        e = '{3'd0, 1'b1, ins[12], a, b, p, 1'b1, 1'b0, 1'b0};
                else if (f3 < 6)        e = '{3'd2, 1'b0, ins[12], a, b, p, 1'b1, 1'b0, 1'b0};
                else                    e = '{3'd3, 1'b0, ins[12], a, b, p, 1'b1, 1'b0, 1'b0};
            end
            7'h03: e = '{3'd0, 1'b0, 1'b0, a, immI, p, 1'b0, 1'b0, 1'b0};
            7'h23: e = '{3'd0, 1'b0, 1'b0, a, immS, p, 1'b0, 1'b0, 1'b0};
            7'h37: e = '{3'd0, 1'b0, 1'b0, 32'd0, immU, p, 1'b0, 1'b0, 1'b0};
            7'h17: e = '{3'd0, 1'b0, 1'b0, p, immU, p, 1'b0, 1'b0, 1'b0};
            7'h6F, 7'h67: e = '{3'd0, 1'b0, 1'b0, p, 32'd4, p, 1'b0, 1'b1, 1'b0};
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_ent(input string name, input exp_t act, input exp_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of model-checked traffic; entered and left at posedge+1
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic ordy, input logic fl, output logic acc);
        logic exp_rdy;
        inValid = v; instr = ins; pc = p; rs1Data = a; rs2Data = b;
        outReady = ordy; flush = fl;
        #1;
        exp_rdy = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || ordy);
        check_bit("inReady", inReady, exp_rdy);
        check_bit("outValid", outValid, q.size() != 0);
        if (q.size() != 0) check_ent("entry", got(), q[0]);
        acc = v && exp_rdy && !fl;
        @(posedge clk); #1;
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (v && exp_rdy) q.push_back(ref_decode(ins, p, a, b));
        end
    endtask

    vec_t        tab[11];
    logic        acc;
    logic [31:0] seq[3];
    int          idx;

    initial begin
        tab[0]  = '{32'h40208133, 32'h0, 7, 3,           '{3'b000, 1'b1, 1'b0, 32'd7, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0}};
        tab[1]  = '{32'hFFF00093, 32'h4, 5, 9,           '{3'b000, 1'b0, 1'b0, 32'd5, 32'hFFFFFFFF, 32'h4, 1'b0, 1'b0, 1'b0}};
        tab[2]  = '{32'h4030D093, 32'h8, 32'h80, 9,      '{3'b101, 1'b1, 1'b0, 32'h80, 32'd3, 32'h8, 1'b0, 1'b0, 1'b0}};
        tab[3]  = '{32'h0020D063, 32'hC, 11, 22,         '{3'b010, 1'b0, 1'b1, 32'd11, 32'd22, 32'hC, 1'b1, 1'b0, 1'b0}};
        tab[4]  = '{32'h00209063, 32'h10, 11, 22,        '{3'b000, 1'b1, 1'b1, 32'd11, 32'd22, 32'h10, 1'b1, 1'b0, 1'b0}};
        tab[5]  = '{32'h0000007F, 32'h14, 11, 22,        '{3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'h14, 1'b0, 1'b0, 1'b1}};
        tab[6]  = '{32'h12345037, 32'h18, 11, 22,        '{3'b000, 1'b0, 1'b0, 32'd0, 32'h12345000, 32'h18, 1'b0, 1'b0, 1'b0}};
        tab[7]  = '{32'h12345017, 32'h100, 11, 22,       '{3'b000, 1'b0, 1'b0, 32'h100, 32'h12345000, 32'h100, 1'b0, 1'b0, 1'b0}};
        tab[8]  = '{32'h0000006F, 32'h200, 11, 22,       '{3'b000, 1'b0, 1'b0, 32'h200, 32'd4, 32'h200, 1'b0, 1'b1, 1'b0}};
        tab[9]  = '{32'hFE20AE23, 32'h24, 32'h1000, 22,  '{3'b000, 1'b0, 1'b0, 32'h1000, 32'hFFFFFFFC, 32'h24, 1'b0, 1'b0, 1'b0}};
        tab[10] = '{32'h0020A063, 32'h28, 11, 22,        '{3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'h28, 1'b0, 1'b0, 1'b1}};

        rstN = 1'b0; inValid = 1'b0; instr = '0; pc = '0; rs1Data = '0; rs2Data = '0;
        flush = 1'b0; outReady = 1'b0;

        // Reset state, checked before any clock edge
        #2;
        check_bit("rst_outValid", outValid, 1'b0);
        check_bit("rst_inReady", inReady, 1'b1);
        check_ent("rst_outputs", got(), '0);
        #10 rstN = 1'b1;
        @(posedge clk); #1;

        // Directed decode table: push, check next cycle, drain
        for (int i = 0; i < 11; i++) begin
            inValid = 1'b1; instr = tab[i].instr; pc = tab[i].pc;
            rs1Data = tab[i].rs1; rs2Data = tab[i].rs2; outReady = 1'b1;
            @(posedge clk); #1;
            inValid = 1'b0;
            #1;
            check_bit("tab_outValid", outValid, 1'b1);
            check_ent($sformatf("tab%0d", i), got(), tab[i].exp);
            @(posedge clk); #1;
        end
        check_bit("tab_drained", outValid, 1'b0);

        // Back-to-back A,B,C with outReady low, then drain in order
        seq[0] = 32'h00100093; seq[1] = 32'h00200113; seq[2] = 32'h00300193;
        idx = 0;
        for (int c = 0; c < 20 && (idx < 3 || q.size() != 0); c++) begin
            cycle(idx < 3, (idx < 3) ? seq[idx] : 32'h0, 32'h300 + 32'(idx * 4),
                  32'h10, 32'h20, c >= 3, 1'b0, acc);
            if (acc) idx++;
        end
        check_bit("abc_all_accepted", idx == 3, 1'b1);
        check_bit("abc_drained", q.size() == 0, 1'b1);

        // Flush while full with a same-cycle input
        cycle(1'b1, 32'h00500293, 32'h400, 1, 2, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h00600313, 32'h404, 1, 2, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h00700393, 32'h408, 1, 2, 1'b0, 1'b1, acc);
        cycle(1'b0, 32'h0, 32'h0, 0, 0, 1'b1, 1'b0, acc);
        cycle(1'b0, 32'h0, 32'h0, 0, 0, 1'b1, 1'b0, acc);

        // Reset asserted mid-stream, between clock edges
        cycle(1'b1, 32'h00800413, 32'h500, 3, 4, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h40208133, 32'h504, 3, 4, 1'b0, 1'b0, acc);
        #2 rstN = 1'b0;
        #1;
        check_bit("midrst_outValid", outValid, 1'b0);
        check_bit("midrst_inReady", inReady, 1'b1);
        check_ent("midrst_outputs", got(), '0);
        q.delete();
        inValid = 1'b0;
        @(negedge clk) rstN = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [6:0]  op;
            logic [31:0] r;
            case ($urandom_range(0, 10))
                0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h63;  3: op = 7'h03;
                4: op = 7'h23;  5: op = 7'h37;  6: op = 7'h17;  7: op = 7'h6F;
                8: op = 7'h67;  9: op = 7'h13;  default: op = 7'($urandom);
            endcase
            r = $urandom;
            cycle($urandom_range(0, 3) != 0, {r[31:7], op}, $urandom, $urandom, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0, acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rstN  input  1  reset, asynchronous assert, active-low.
REQ-003 inValid/inReady  input/output  1/1  upstream valid/ready handshake.
REQ-004 instr, pc, rs1Data, rs2Data  input  32 each  RV32I instruction, its PC, register operands.
REQ-005 flush  input  1  discards all held entries.
REQ-006 outValid/outReady  output/input  1/1  downstream (ALU side) handshake.
REQ-007 aluCntrl  output  3  ALU operation select.
REQ-008 useF7, inv  output  1 each  ALU sub/arith-shift select; branch-compare inversion.
REQ-009 srcA, srcB  output  32 each  ALU operands.
REQ-010 outPc, isBranch, isJump, illegal  output  32/1/1/1  PC passthrough and class flags.

Function
REQ-011 Transfer in when inValid&&inReady; transfer out when outValid&&outReady; all outputs come from registers, never combinationally from inputs.
REQ-012 Decode by opcode; OP (0110011): aluCntrl=funct3, useF7=instr[30], srcA=rs1Data, srcB=rs2Data.
REQ-013 OP-IMM (0010011): aluCntrl=funct3, useF7=instr[30] only if funct3==101 else 0, srcB=sign-extended I-imm (shifts: instr[24:20] zero-extended).
REQ-014 BRANCH (1100011): isBranch=1, srcA=rs1Data, srcB=rs2Data, inv=funct3[0]; funct3 00x -> aluCntrl 000, useF7 1; 10x -> 010, useF7 0; 11x -> 011, useF7 0; funct3 01x -> illegal.
REQ-015 LOAD/STORE: aluCntrl 000, useF7 0, srcA=rs1Data, srcB=sign-extended I-imm / S-imm.
REQ-016 LUI: srcA=0, srcB={instr[31:12],12'b0}; AUIPC: srcA=pc, same srcB; both aluCntrl 000, useF7 0.
REQ-017 JAL/JALR: isJump=1, srcA=pc, srcB=32'd4, aluCntrl 000, useF7 0.
REQ-018 Any other opcode: illegal=1, aluCntrl 000, useF7 0, inv 0, srcA=srcB=0; entry still flows through the handshake.
REQ-019 inv=0 for every non-branch; isBranch, isJump, illegal mutually exclusive.
REQ-020 Entry, once outValid, holds all outputs stable until accepted (no change while outValid&&!outReady).
REQ-021 Occupancy FSM: EMPTY, ONE, TWO (TWO only with skid, REQ-030); in-only: EMPTY->ONE, ONE->TWO; out-only: TWO->ONE, ONE->EMPTY; simultaneous in+out keeps state, FIFO order preserved.
REQ-022 inReady=1 in EMPTY and ONE, 0 in TWO.
REQ-023 flush has priority over all transfers: next state EMPTY, outValid=0 next cycle, same-cycle input dropped.

Reset
REQ-024 rstN low: state EMPTY, outValid 0, inReady 1 (after reset), all data outputs 0, flags 0, regardless of clock.
REQ-025 Reset mid-transfer discards all entries; first post-reset transfer needs inValid in a clock edge with rstN high.

Configuration
REQ-030 Macro DECODE_SKID_EN defined: two-entry skid buffer per REQ-021/022, sustained one transfer per cycle with inReady registered.
REQ-031 DECODE_SKID_EN undefined: single entry (EMPTY/ONE only), inReady = !outValid || outReady (combinational), same decode and flush/reset behaviour.

Verification
REQ-040 instr 0x40208133 (sub), rs1Data 7, rs2Data 3, outReady 1 -> one cycle later outValid 1, aluCntrl 000, useF7 1, srcA 7, srcB 3, inv 0.
REQ-041 instr 0xFFF00093 (addi -1) -> srcB 0xFFFFFFFF, useF7 0; instr 0x4030D093 (srai 3) -> aluCntrl 101, useF7 1, srcB 3.
REQ-042 BGE (funct3 101) and BNE (funct3 001) -> aluCntrl 010/inv 1/useF7 0 and aluCntrl 000/inv 1/useF7 1, isBranch 1.
REQ-043 outReady 0, three back-to-back inputs A,B,C with DECODE_SKID_EN -> A,B held, inReady 0 at C; outReady 1 -> A,B,C emerge in order, none lost or duplicated.
REQ-044 flush asserted with state TWO and inValid 1 -> next cycle outValid 0, inReady 1, input dropped; rstN pulse mid-stream -> all outputs 0 immediately.
REQ-045 opcode 0x7F -> illegal 1, srcA 0, srcB 0, passes handshake normally.
